axi_lite_bram_ctrl: RTL

AXI4-lite slave that sequences the single-port-pair block RAM (32-bit data, 16-bit word address, 1-cycle registered read with data_valid). It converts AW/W/B and AR/R transactions into RAM write and read strobes. It arbitrates between simultaneous read and write requests, and it guarantees that the RAM's write-enable and read-enable are never asserted in the same cycle. It sits between the AXI4-lite interconnect and the block RAM.

---
 rtl/axi_lite_bram_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_bram_ctrl.sv
// rtl/axi_lite_bram_ctrl.sv - AXI4-lite slave sequencing a single-port-pair block RAM
//
// Converts AXI4-lite AW/W/B and AR/R transactions into one-cycle RAM write and
// read strobes, one transaction in flight at a time. Simultaneous read and
// write requests are arbitrated round-robin. ram_wr_en and ram_rd_en come from
// mutually exclusive states, so they can never be high together.
//
// Ports:
//   clk, reset_n            clock (rising edge), synchronous active-low reset
//   s_aw* / s_w* / s_b*     AXI4-lite write address, write data, write response
//   s_ar* / s_r*            AXI4-lite read address, read data/response
//   ram_wr_addr/ram_data_in RAM write word address and data
//   ram_rd_addr             RAM read word address
//   ram_wr_en / ram_rd_en   RAM strobes, one cycle each
//   ram_data_valid/_out     RAM registered read data (one cycle after ram_rd_en)
module axi_lite_bram_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [REG_DATA_WIDTH-1:0]   s_wdata,
    input  logic [REG_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [REG_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [ADDRESS_WIDTH-1:0]    ram_wr_addr,
    output logic [ADDRESS_WIDTH-1:0]    ram_rd_addr,
    output logic [REG_DATA_WIDTH-1:0]   ram_data_in,
    output logic                        ram_wr_en,
    output logic                        ram_rd_en,
    input  logic                        ram_data_valid,
    input  logic [REG_DATA_WIDTH-1:0]   ram_data_out
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_EXEC,
        RD_WAIT,
        RD_RESP
    } state_t;

    typedef enum logic {
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

    state_t                      state_q, state_d;
    grant_t                      last_grant_q, last_grant_d;
    logic [ADDRESS_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [ADDRESS_WIDTH-1:0]    rd_addr_q, rd_addr_d;
    logic [REG_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [REG_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        rvalid_q, rvalid_d;

    logic wr_req;
    logic rd_req;
    logic grant_wr;
    logic grant_rd;

    // Byte-lane offset bits carry no meaning for whole-word RAM accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    // Any address bit above the RAM's byte range makes the access a decode error.
    function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr >> (ADDRESS_WIDTH + 2)) != '0;
    endfunction

    assign wr_req = s_awvalid & s_wvalid;
    assign rd_req = s_arvalid;

    // On a collision the type not granted last time wins. Grants are held off
    // while reset_n is low so nothing is accepted on the reset edge.
    assign grant_wr = (state_q == IDLE) & reset_n & wr_req &
                      (~rd_req | (last_grant_q == GRANT_READ));
    assign grant_rd = (state_q == IDLE) & reset_n & rd_req & ~grant_wr;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_data_d    = wr_data_q;
        bresp_d      = bresp_q;
        bvalid_d     = bvalid_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        rvalid_d     = rvalid_q;

        case (state_q)
            IDLE: begin
                // last_grant only tracks contested cycles; an uncontested grant
                // leaves the round-robin pointer where it was.
                if (wr_req && rd_req && reset_n) begin
                    last_grant_d = grant_wr ? GRANT_WRITE : GRANT_READ;
                end
                if (grant_wr) begin
                    wr_addr_d = s_awaddr[ADDRESS_WIDTH+1:2];
                    wr_data_d = s_wdata;
                    if (out_of_range(s_awaddr)) begin
                        bresp_d  = RESP_DECERR;
                        bvalid_d = 1'b1;
                        state_d  = WR_RESP;
                    end else if (!(&s_wstrb)) begin
                        // Partial-word writes are refused rather than merged.
                        bresp_d  = RESP_SLVERR;
                        bvalid_d = 1'b1;
                        state_d  = WR_RESP;
                    end else begin
                        state_d = WR_EXEC;
                    end
                end else if (grant_rd) begin
                    rd_addr_d = s_araddr[ADDRESS_WIDTH+1:2];
                    if (out_of_range(s_araddr)) begin
                        rdata_d  = '0;
                        rresp_d  = RESP_DECERR;
                        rvalid_d = 1'b1;
                        state_d  = RD_RESP;
                    end else begin
                        state_d = RD_EXEC;
                    end
                end
            end
            WR_EXEC: begin
                bresp_d  = RESP_OKAY;
                bvalid_d = 1'b1;
                state_d  = WR_RESP;
            end
            WR_RESP: begin
                if (s_bready) begin
                    bresp_d  = RESP_OKAY;
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD_EXEC: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // RAM data is registered, so it is present one cycle after the strobe.
                if (ram_data_valid) begin
                    rdata_d = ram_data_out;
                    rresp_d = RESP_OKAY;
                end else begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
                rvalid_d = 1'b1;
                state_d  = RD_RESP;
            end
            RD_RESP: begin
                if (s_rready) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_OKAY;
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_READ;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_data_q    <= '0;
            bresp_q      <= RESP_OKAY;
            bvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_data_q    <= wr_data_d;
            bresp_q      <= bresp_d;
            bvalid_q     <= bvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign s_awready   = grant_wr;
    assign s_wready    = grant_wr;
    assign s_arready   = grant_rd;
    assign s_bresp     = bresp_q;
    assign s_bvalid    = bvalid_q;
    assign s_rresp     = rresp_q;
    assign s_rdata     = rdata_q;
    assign s_rvalid    = rvalid_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_rd_addr = rd_addr_q;
    assign ram_data_in = wr_data_q;
    assign ram_wr_en   = (state_q == WR_EXEC);
    assign ram_rd_en   = (state_q == RD_EXEC);

endmodule
